// File: rtl/bitrev_frame_buf_if.sv
// bitrev_frame_buf_if: sample-in / reordered-sample-out streaming bus for bitrev_frame_buf
interface bitrev_frame_buf_if #(
  parameter int N_LOG2 = 4,
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              rev_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [N_LOG2-1:0] out_idx;
  logic              out_last;
  modport master (
    output in_valid, in_data, rev_en, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );
  modport slave (
    input  in_valid, in_data, rev_en, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/bitrev_frame_buf.sv
// bitrev_frame_buf: ping-pong frame buffer emitting each frame in bit-reversed or natural order
module bitrev_frame_buf #(
  parameter int N_LOG2 = 4,
  parameter int DATA_W = 64
) (
  input logic clk,
  input logic rst,
  bitrev_frame_buf_if.slave bus
);
  localparam int N = 1 << N_LOG2;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_t;
  bank_t             st [2];
  bank_t             st_n [2];
  logic              rev [2];
  logic              wb, rb;
  logic [N_LOG2-1:0] wcnt, rcnt, waddr;
  logic [DATA_W-1:0] mem [2][N];
  logic              wr, rd, wrev;
  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] x);
    for (int i = 0; i < N_LOG2; i++) bitrev[i] = x[N_LOG2-1-i];
  endfunction
  // reordering happens on the write side; reads always walk slots 0..N-1
  always_comb begin
    bus.in_ready  = st[wb] != FULL;
    bus.out_valid = st[rb] == FULL;
    bus.out_data  = mem[rb][rcnt];
    bus.out_idx   = rev[rb] ? bitrev(rcnt) : rcnt;
    bus.out_last  = bus.out_valid && &rcnt;
    wr            = bus.in_valid && bus.in_ready;
    rd            = bus.out_valid && bus.out_ready;
    wrev          = st[wb] == EMPTY ? bus.rev_en : rev[wb];
    waddr         = wrev ? bitrev(wcnt) : wcnt;
    st_n          = st;
    if (wr) st_n[wb] = &wcnt ? FULL : FILLING;
    if (rd && bus.out_last) st_n[rb] = EMPTY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= '{EMPTY, EMPTY};
      rev  <= '{1'b0, 1'b0};
      wb   <= 1'b0;
      rb   <= 1'b0;
      wcnt <= '0;
      rcnt <= '0;
    end else begin
      st <= st_n;
      if (wr) begin
        wcnt <= wcnt + 1'b1;
        if (st[wb] == EMPTY) rev[wb] <= bus.rev_en;
        if (&wcnt) wb <= ~wb;
      end
      if (rd) begin
        rcnt <= rcnt + 1'b1;
        if (&rcnt) rb <= ~rb;
      end
    end
  end
  always_ff @(posedge clk) if (wr) mem[wb][waddr] <= bus.in_data;
endmodule
